// File: rtl/lsu_mem_arbiter.sv
// Round-robin arbiter sharing NUM_CHANNELS data-memory channels among NUM_CONSUMERS LSU ports.
// Optional perf counters (perf_grant_count / perf_stall_count) exist when LSU_MEM_ARBITER_PERF_EN is defined.
module lsu_mem_arbiter #(
   parameter int unsigned ADDR_BITS     = 8,
   parameter int unsigned DATA_BITS     = 8,
   parameter int unsigned NUM_CONSUMERS = 4,
   parameter int unsigned NUM_CHANNELS  = 1
) (
   input  logic                                    clk,
   input  logic                                    reset,
   input  logic [NUM_CONSUMERS-1:0]                consumer_read_valid,
   input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0] consumer_read_address,
   output logic [NUM_CONSUMERS-1:0]                consumer_read_ready,
   output logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] consumer_read_data,
   input  logic [NUM_CONSUMERS-1:0]                consumer_write_valid,
   input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0] consumer_write_address,
   input  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] consumer_write_data,
   output logic [NUM_CONSUMERS-1:0]                consumer_write_ready,
   output logic [NUM_CHANNELS-1:0]                 mem_read_valid,
   output logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]  mem_read_address,
   input  logic [NUM_CHANNELS-1:0]                 mem_read_ready,
   input  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]  mem_read_data,
   output logic [NUM_CHANNELS-1:0]                 mem_write_valid,
   output logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]  mem_write_address,
   output logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]  mem_write_data,
   input  logic [NUM_CHANNELS-1:0]                 mem_write_ready
`ifdef LSU_MEM_ARBITER_PERF_EN
   ,
   output logic [15:0]                             perf_grant_count,
   output logic [15:0]                             perf_stall_count
`endif
);

   localparam int unsigned IDX_W = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;
   localparam int unsigned CNT_W = 16;

   typedef enum logic [1:0] {
      S_IDLE,
      S_READ_WAIT,
      S_WRITE_WAIT,
      S_RELAY
   } state_e;

   state_e                                  state_q [NUM_CHANNELS];
   state_e                                  state_d [NUM_CHANNELS];
   logic [NUM_CHANNELS-1:0][IDX_W-1:0]      owner_q, owner_d;
   logic [NUM_CHANNELS-1:0]                 is_write_q, is_write_d;
   logic [NUM_CHANNELS-1:0]                 mem_rd_valid_q, mem_rd_valid_d;
   logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]  mem_rd_addr_q, mem_rd_addr_d;
   logic [NUM_CHANNELS-1:0]                 mem_wr_valid_q, mem_wr_valid_d;
   logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]  mem_wr_addr_q, mem_wr_addr_d;
   logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]  mem_wr_data_q, mem_wr_data_d;
   logic [NUM_CONSUMERS-1:0]                rd_ready_q, rd_ready_d;
   logic [NUM_CONSUMERS-1:0]                wr_ready_q, wr_ready_d;
   logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] rd_data_q, rd_data_d;
   logic [NUM_CONSUMERS-1:0]                claim_q, claim_d;
   logic [IDX_W-1:0]                        rr_ptr_q, rr_ptr_d;

   logic [NUM_CONSUMERS-1:0]                req_any;
   logic [NUM_CONSUMERS-1:0]                taken;
   logic                                    found;
   logic [IDX_W-1:0]                        pick;
   logic [IDX_W-1:0]                        scan_idx;
   logic [IDX_W:0]                          scan_sum;
   logic [IDX_W:0]                          next_ptr;

   assign req_any = consumer_read_valid | consumer_write_valid;

   // Channel FSMs; `taken` accumulates claims plus this cycle's grants so lower channels win first.
   always_comb begin
      state_d        = state_q;
      owner_d        = owner_q;
      is_write_d     = is_write_q;
      mem_rd_valid_d = mem_rd_valid_q;
      mem_rd_addr_d  = mem_rd_addr_q;
      mem_wr_valid_d = mem_wr_valid_q;
      mem_wr_addr_d  = mem_wr_addr_q;
      mem_wr_data_d  = mem_wr_data_q;
      rd_ready_d     = rd_ready_q;
      wr_ready_d     = wr_ready_q;
      rd_data_d      = rd_data_q;
      claim_d        = claim_q;
      rr_ptr_d       = rr_ptr_q;
      taken          = claim_q;
      found          = 1'b0;
      pick           = '0;
      scan_idx       = '0;
      scan_sum       = '0;
      next_ptr       = '0;

      for (int c = 0; c < NUM_CHANNELS; c++) begin
         found = 1'b0;
         pick  = '0;
         case (state_q[c])
            S_IDLE: begin
               for (int unsigned i = 0; i < NUM_CONSUMERS; i++) begin
                  scan_sum = {1'b0, rr_ptr_q} + (IDX_W+1)'(i);
                  if (scan_sum >= (IDX_W+1)'(NUM_CONSUMERS)) begin
                     scan_sum = scan_sum - (IDX_W+1)'(NUM_CONSUMERS);
                  end
                  scan_idx = scan_sum[IDX_W-1:0];
                  if (!found && req_any[scan_idx] && !taken[scan_idx]) begin
                     found = 1'b1;
                     pick  = scan_idx;
                  end
               end
               if (found) begin
                  taken[pick]   = 1'b1;
                  claim_d[pick] = 1'b1;
                  owner_d[c]    = pick;
                  next_ptr      = {1'b0, pick} + (IDX_W+1)'(1);
                  rr_ptr_d      = (next_ptr == (IDX_W+1)'(NUM_CONSUMERS)) ? '0 : next_ptr[IDX_W-1:0];
                  if (consumer_read_valid[pick]) begin
                     is_write_d[c]     = 1'b0;
                     mem_rd_valid_d[c] = 1'b1;
                     mem_rd_addr_d[c]  = consumer_read_address[pick];
                     state_d[c]        = S_READ_WAIT;
                  end else begin
                     is_write_d[c]     = 1'b1;
                     mem_wr_valid_d[c] = 1'b1;
                     mem_wr_addr_d[c]  = consumer_write_address[pick];
                     mem_wr_data_d[c]  = consumer_write_data[pick];
                     state_d[c]        = S_WRITE_WAIT;
                  end
               end
            end
            S_READ_WAIT: begin
               if (mem_read_ready[c]) begin
                  mem_rd_valid_d[c]     = 1'b0;
                  rd_data_d[owner_q[c]] = mem_read_data[c];
                  rd_ready_d[owner_q[c]] = 1'b1;
                  state_d[c]            = S_RELAY;
               end
            end
            S_WRITE_WAIT: begin
               if (mem_write_ready[c]) begin
                  mem_wr_valid_d[c]      = 1'b0;
                  wr_ready_d[owner_q[c]] = 1'b1;
                  state_d[c]             = S_RELAY;
               end
            end
            S_RELAY: begin
               // Ready is held until the LSU drops its valid; only then is the consumer released.
               if (is_write_q[c] ? !consumer_write_valid[owner_q[c]]
                                 : !consumer_read_valid[owner_q[c]]) begin
                  rd_ready_d[owner_q[c]] = 1'b0;
                  wr_ready_d[owner_q[c]] = 1'b0;
                  claim_d[owner_q[c]]    = 1'b0;
                  state_d[c]             = S_IDLE;
               end
            end
            default: state_d[c] = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int c = 0; c < NUM_CHANNELS; c++) begin
            state_q[c] <= S_IDLE;
         end
         owner_q        <= '0;
         is_write_q     <= '0;
         mem_rd_valid_q <= '0;
         mem_rd_addr_q  <= '0;
         mem_wr_valid_q <= '0;
         mem_wr_addr_q  <= '0;
         mem_wr_data_q  <= '0;
         rd_ready_q     <= '0;
         wr_ready_q     <= '0;
         rd_data_q      <= '0;
         claim_q        <= '0;
         rr_ptr_q       <= '0;
      end else begin
         state_q        <= state_d;
         owner_q        <= owner_d;
         is_write_q     <= is_write_d;
         mem_rd_valid_q <= mem_rd_valid_d;
         mem_rd_addr_q  <= mem_rd_addr_d;
         mem_wr_valid_q <= mem_wr_valid_d;
         mem_wr_addr_q  <= mem_wr_addr_d;
         mem_wr_data_q  <= mem_wr_data_d;
         rd_ready_q     <= rd_ready_d;
         wr_ready_q     <= wr_ready_d;
         rd_data_q      <= rd_data_d;
         claim_q        <= claim_d;
         rr_ptr_q       <= rr_ptr_d;
      end
   end

   assign consumer_read_ready  = rd_ready_q;
   assign consumer_read_data   = rd_data_q;
   assign consumer_write_ready = wr_ready_q;
   assign mem_read_valid       = mem_rd_valid_q;
   assign mem_read_address     = mem_rd_addr_q;
   assign mem_write_valid      = mem_wr_valid_q;
   assign mem_write_address    = mem_wr_addr_q;
   assign mem_write_data       = mem_wr_data_q;

`ifdef LSU_MEM_ARBITER_PERF_EN
   logic [CNT_W-1:0] perf_grant_q, perf_grant_d;
   logic [CNT_W-1:0] perf_stall_q, perf_stall_d;
   logic [CNT_W:0]   grant_sum;

   // Saturating counters; a stall is an unclaimed requester left ungranted this cycle.
   always_comb begin
      grant_sum    = {1'b0, perf_grant_q} + (CNT_W+1)'($countones(taken & ~claim_q));
      perf_grant_d = grant_sum[CNT_W] ? '1 : grant_sum[CNT_W-1:0];
      perf_stall_d = perf_stall_q;
      if ((|(req_any & ~taken)) && (perf_stall_q != '1)) begin
         perf_stall_d = perf_stall_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         perf_grant_q <= '0;
         perf_stall_q <= '0;
      end else begin
         perf_grant_q <= perf_grant_d;
         perf_stall_q <= perf_stall_d;
      end
   end

   assign perf_grant_count = perf_grant_q;
   assign perf_stall_count = perf_stall_q;
`endif

endmodule

// File: tb/tb_lsu_mem_arbiter.sv
// Directed bench for lsu_mem_arbiter: a 1-channel instance (A) and a 2-channel instance (B)
// with simple memory responders; perf counter checks are built when LSU_MEM_ARBITER_PERF_EN is defined.
module tb_lsu_mem_arbiter;
   localparam int unsigned AW = 8;
   localparam int unsigned DW = 8;
   localparam int unsigned NC = 4;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // instance A: one channel
   logic [NC-1:0]         crv = '0, cwv = '0;
   logic [NC-1:0][AW-1:0] cra = '0, cwa = '0;
   logic [NC-1:0][DW-1:0] cwd = '0;
   logic [NC-1:0]         crr, cwr;
   logic [NC-1:0][DW-1:0] crd;
   logic [0:0]            mrv, mwv;
   logic [0:0]            mrr = 1'b0, mwr = 1'b0;
   logic [0:0][AW-1:0]    mra, mwa;
   logic [0:0][DW-1:0]    mrd = '0, mwd;

   // instance B: two channels
   logic [NC-1:0]         crv_b = '0, cwv_b = '0;
   logic [NC-1:0][AW-1:0] cra_b = '0, cwa_b = '0;
   logic [NC-1:0][DW-1:0] cwd_b = '0;
   logic [NC-1:0]         crr_b, cwr_b;
   logic [NC-1:0][DW-1:0] crd_b;
   logic [1:0]            mrv_b, mwv_b;
   logic [1:0]            mrr_b = '0, mwr_b = '0;
   logic [1:0][AW-1:0]    mra_b, mwa_b;
   logic [1:0][DW-1:0]    mrd_b = '0, mwd_b;

`ifdef LSU_MEM_ARBITER_PERF_EN
   logic [15:0] pg_a, ps_a, pg_b, ps_b;
`endif

   lsu_mem_arbiter #(.ADDR_BITS(AW), .DATA_BITS(DW), .NUM_CONSUMERS(NC), .NUM_CHANNELS(1)) dut_a (
      .clk(clk), .reset(reset),
      .consumer_read_valid(crv), .consumer_read_address(cra),
      .consumer_read_ready(crr), .consumer_read_data(crd),
      .consumer_write_valid(cwv), .consumer_write_address(cwa),
      .consumer_write_data(cwd), .consumer_write_ready(cwr),
      .mem_read_valid(mrv), .mem_read_address(mra), .mem_read_ready(mrr), .mem_read_data(mrd),
      .mem_write_valid(mwv), .mem_write_address(mwa), .mem_write_data(mwd), .mem_write_ready(mwr)
`ifdef LSU_MEM_ARBITER_PERF_EN
      , .perf_grant_count(pg_a), .perf_stall_count(ps_a)
`endif
   );

   lsu_mem_arbiter #(.ADDR_BITS(AW), .DATA_BITS(DW), .NUM_CONSUMERS(NC), .NUM_CHANNELS(2)) dut_b (
      .clk(clk), .reset(reset),
      .consumer_read_valid(crv_b), .consumer_read_address(cra_b),
      .consumer_read_ready(crr_b), .consumer_read_data(crd_b),
      .consumer_write_valid(cwv_b), .consumer_write_address(cwa_b),
      .consumer_write_data(cwd_b), .consumer_write_ready(cwr_b),
      .mem_read_valid(mrv_b), .mem_read_address(mra_b), .mem_read_ready(mrr_b), .mem_read_data(mrd_b),
      .mem_write_valid(mwv_b), .mem_write_address(mwa_b), .mem_write_data(mwd_b), .mem_write_ready(mwr_b)
`ifdef LSU_MEM_ARBITER_PERF_EN
      , .perf_grant_count(pg_b), .perf_stall_count(ps_b)
`endif
   );

   // Memory A: unwritten words read as addr ^ 0xB5; answers after `lat` cycles of valid.
   int            lat  = 1;
   int            rcnt = 0;
   int            wcnt = 0;
   logic [DW-1:0] mem_a [256];
   logic          wr_a  [256] = '{default: 1'b0};

   always @(negedge clk) begin
      if (mrr[0]) mrr[0] = 1'b0;
      else if (mrv[0]) begin
         rcnt++;
         if (rcnt >= lat) begin
            mrr[0] = 1'b1;
            mrd[0] = wr_a[mra[0]] ? mem_a[mra[0]] : (mra[0] ^ 8'hB5);
            rcnt   = 0;
         end
      end else rcnt = 0;
      if (mwr[0]) mwr[0] = 1'b0;
      else if (mwv[0]) begin
         wcnt++;
         if (wcnt >= lat) begin
            mwr[0]          = 1'b1;
            mem_a[mwa[0]]   = mwd[0];
            wr_a[mwa[0]]    = 1'b1;
            wcnt            = 0;
         end
      end else wcnt = 0;
   end

   // Memory B: reads answer the next cycle with addr ^ 0xC3.
   always @(negedge clk) begin
      for (int c = 0; c < 2; c++) begin
         if (mrr_b[c]) mrr_b[c] = 1'b0;
         else if (mrv_b[c]) begin
            mrr_b[c] = 1'b1;
            mrd_b[c] = mra_b[c] ^ 8'hC3;
         end
         if (mwr_b[c]) mwr_b[c] = 1'b0;
         else if (mwv_b[c]) mwr_b[c] = 1'b1;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_rd(input int k, input int lim);
      int n = 0;
      while (!crr[k] && n < lim) begin
         tick();
         n++;
      end
      chk($sformatf("rd_ready_c%0d", k), 32'(crr[k]), 32'd1);
   endtask

   task automatic wait_wr(input int k, input int lim);
      int n = 0;
      while (!cwr[k] && n < lim) begin
         tick();
         n++;
      end
      chk($sformatf("wr_ready_c%0d", k), 32'(cwr[k]), 32'd1);
   endtask

   logic [7:0] order [8];
   logic [7:0] exp_order [5] = '{8'h40, 8'h41, 8'h42, 8'h43, 8'h40};
   int         ngr;
   logic       prev, pend0, re0;

   initial begin
      // reset state
      tick();
      tick();
      chk("rst_crr", 32'(crr), 32'h0);
      chk("rst_cwr", 32'(cwr), 32'h0);
      chk("rst_crd", 32'(crd), 32'h0);
      chk("rst_mrv", 32'(mrv), 32'h0);
      chk("rst_mwv", 32'(mwv), 32'h0);
      chk("rst_mrv_b", 32'(mrv_b), 32'h0);
      reset = 1'b1;

      // two channels: consumers 1 and 3 granted in the same cycle
      cra_b[1] = 8'h61;
      cra_b[3] = 8'h63;
      crv_b    = 4'b1010;
      tick();
      chk("b_mrv", 32'(mrv_b), 32'h3);
      chk("b_ch0_addr", 32'(mra_b[0]), 32'h61);
      chk("b_ch1_addr", 32'(mra_b[1]), 32'h63);
      chk("b_mwv", 32'(mwv_b), 32'h0);
      chk("b_mwa", 32'(mwa_b), 32'h0);
      chk("b_mwd", 32'(mwd_b), 32'h0);
      tick();
      chk("b_crr", 32'(crr_b), 32'hA);
      chk("b_crd1", 32'(crd_b[1]), 32'hA2);
      chk("b_crd3", 32'(crd_b[3]), 32'hA0);
      crv_b = '0;
      tick();
      chk("b_crr_drop", 32'(crr_b), 32'h0);
      chk("b_cwr", 32'(cwr_b), 32'h0);

      // single read, latency 3; address change after grant ignored
      lat    = 3;
      cra[2] = 8'h10;
      crv[2] = 1'b1;
      tick();
      chk("t1_mrv", 32'(mrv), 32'h1);
      chk("t1_addr", 32'(mra[0]), 32'h10);
      cra[2] = 8'h11;
      tick();
      chk("t1_addr_held", 32'(mra[0]), 32'h10);
      chk("t1_crr_early1", 32'(crr), 32'h0);
      tick();
      chk("t1_crr_early2", 32'(crr), 32'h0);
      tick();
      chk("t1_crr", 32'(crr), 32'h4);
      chk("t1_crd", 32'(crd[2]), 32'hA5);
      chk("t1_mrv_low", 32'(mrv), 32'h0);
      tick();
      chk("t1_crr_hold", 32'(crr), 32'h4);
      crv[2] = 1'b0;
      tick();
      chk("t1_crr_drop", 32'(crr), 32'h0);
      chk("t1_crd_keep", 32'(crd[2]), 32'hA5);

      // round robin from rr_ptr=0, consumer 0 re-requests after its first completion
      reset = 1'b0;
      tick();
      reset = 1'b1;
      lat   = 1;
      for (int i = 0; i < 4; i++) cra[i] = 8'h40 + 8'(i);
      crv   = 4'hF;
      ngr   = 0;
      prev  = 1'b0;
      pend0 = 1'b0;
      re0   = 1'b0;
      for (int n = 0; n < 60; n++) begin
         tick();
         if (mrv[0] && !prev && ngr < 8) begin
            order[ngr] = mra[0];
            ngr++;
         end
         prev = mrv[0];
         for (int k = 0; k < 4; k++) begin
            if (crr[k] && crv[k]) begin
               chk($sformatf("rr_data_c%0d", k), 32'(crd[k]), 32'((8'h40 + 8'(k)) ^ 8'hB5));
               crv[k] = 1'b0;
               if (k == 0 && !re0) pend0 = 1'b1;
            end
         end
         if (pend0 && !crr[0]) begin
            crv[0] = 1'b1;
            pend0  = 1'b0;
            re0    = 1'b1;
         end
         if (ngr == 5 && crv == '0 && crr == '0) break;
      end
      chk("rr_ngrants", 32'(ngr), 32'd5);
      for (int i = 0; i < 5; i++) chk($sformatf("rr_order%0d", i), 32'(order[i]), 32'(exp_order[i]));

      // write by consumer 0 precedes read by consumer 1 of the same address
      reset = 1'b0;
      tick();
      reset  = 1'b1;
      lat    = 2;
      cwa[0] = 8'h20;
      cwd[0] = 8'h3C;
      cwv[0] = 1'b1;
      cra[1] = 8'h20;
      crv[1] = 1'b1;
      tick();
      chk("t3_mwv", 32'(mwv), 32'h1);
      chk("t3_mrv", 32'(mrv), 32'h0);
      chk("t3_mwa", 32'(mwa[0]), 32'h20);
      chk("t3_mwd", 32'(mwd[0]), 32'h3C);
      wait_wr(0, 20);
      cwv[0] = 1'b0;
      wait_rd(1, 20);
      chk("t3_rd_data", 32'(crd[1]), 32'h3C);
      crv[1] = 1'b0;
      tick();

      // read wins when both valids are high
      cra[2] = 8'h30;
      cwa[2] = 8'h31;
      crv[2] = 1'b1;
      cwv[2] = 1'b1;
      tick();
      tick();
      chk("rw_mrv", 32'(mrv), 32'h1);
      chk("rw_mwv", 32'(mwv), 32'h0);
      chk("rw_addr", 32'(mra[0]), 32'h30);
      wait_rd(2, 20);
      chk("rw_data", 32'(crd[2]), 32'h85);
      crv[2] = 1'b0;
      cwv[2] = 1'b0;
      tick();
      chk("rw_release", 32'({crr, cwr}), 32'h0);
      tick();

      // reset during READ_WAIT, then a fresh request starts from rr_ptr=0
      lat    = 5;
      cra[1] = 8'h44;
      crv[1] = 1'b1;
      tick();
      chk("t4_mrv", 32'(mrv), 32'h1);
      chk("t4_addr", 32'(mra[0]), 32'h44);
      tick();
      reset = 1'b0;
      crv   = '0;
      tick();
      chk("t4_rst_mrv", 32'(mrv), 32'h0);
      chk("t4_rst_mra", 32'(mra[0]), 32'h0);
      chk("t4_rst_crr", 32'(crr), 32'h0);
      chk("t4_rst_crd", 32'(crd), 32'h0);
      chk("t4_rst_mwv", 32'(mwv), 32'h0);
      reset  = 1'b1;
      cra[0] = 8'h50;
      cra[2] = 8'h52;
      crv    = 4'b0101;
      tick();
      chk("t4_first_grant", 32'(mra[0]), 32'h50);
      wait_rd(0, 20);
      chk("t4_data0", 32'(crd[0]), 32'hE5);
      crv[0] = 1'b0;
      wait_rd(2, 30);
      chk("t4_data2", 32'(crd[2]), 32'hE7);
      crv[2] = 1'b0;
      tick();
      tick();

`ifdef LSU_MEM_ARBITER_PERF_EN
      // four simultaneous requests, latency 2
      reset = 1'b0;
      tick();
      reset = 1'b1;
      chk("pf_rst_grant", 32'(pg_a), 32'h0);
      chk("pf_rst_stall", 32'(ps_a), 32'h0);
      lat = 2;
      for (int i = 0; i < 4; i++) cra[i] = 8'h40 + 8'(i);
      crv = 4'hF;
      for (int n = 0; n < 80; n++) begin
         tick();
         for (int k = 0; k < 4; k++) if (crr[k] && crv[k]) crv[k] = 1'b0;
         if (crv == '0 && crr == '0) break;
      end
      chk("pf_grant", 32'(pg_a), 32'd4);
      chk("pf_stall_nz", 32'(ps_a != 16'h0), 32'h1);

      // consumer 0 parks in RELAY, consumer 1 stalls until the counter saturates
      reset = 1'b0;
      tick();
      reset = 1'b1;
      crv   = 4'b0011;
      repeat (65600) tick();
      chk("pf_stall_sat", 32'(ps_a), 32'hFFFF);
      chk("pf_grant_one", 32'(pg_a), 32'd1);
      crv = '0;
      tick();
      tick();
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/lsu_mem_arbiter.md
Name: lsu_mem_arbiter

Overview:
- Data-memory controller that shares NUM_CHANNELS physical memory channels among NUM_CONSUMERS LSU request ports. A consumer port is one thread LSU: the data_mem_* vectors of all cores, concatenated.
- Sits between the cores' data_mem_* ports and global data memory.
- Arbitration is round-robin with per-channel FSMs. Per-consumer valid/ready semantics are exactly those the LSU expects.

Parameters:
- ADDR_BITS, 8, data memory address width
- DATA_BITS, 8, data memory word width
- NUM_CONSUMERS, 4, number of LSU request ports (>=1)
- NUM_CHANNELS, 1, number of memory channels (1..NUM_CONSUMERS)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset
- consumer_read_valid  in  NUM_CONSUMERS  per-consumer read request, held until ready
- consumer_read_address  in  ADDR_BITS x NUM_CONSUMERS  read address
- consumer_read_ready  out  NUM_CONSUMERS  read complete; data valid
- consumer_read_data  out  DATA_BITS x NUM_CONSUMERS  returned read data
- consumer_write_valid  in  NUM_CONSUMERS  per-consumer write request, held until ready
- consumer_write_address  in  ADDR_BITS x NUM_CONSUMERS  write address
- consumer_write_data  in  DATA_BITS x NUM_CONSUMERS  write data
- consumer_write_ready  out  NUM_CONSUMERS  write complete
- mem_read_valid  out  NUM_CHANNELS  channel read request
- mem_read_address  out  ADDR_BITS x NUM_CHANNELS  channel read address
- mem_read_ready  in  NUM_CHANNELS  memory read done
- mem_read_data  in  DATA_BITS x NUM_CHANNELS  memory read data
- mem_write_valid  out  NUM_CHANNELS  channel write request
- mem_write_address  out  ADDR_BITS x NUM_CHANNELS  channel write address
- mem_write_data  out  DATA_BITS x NUM_CHANNELS  channel write data
- mem_write_ready  in  NUM_CHANNELS  memory write done

Behaviour:
- Reset (reset==0 at posedge):
  - All outputs go to 0. All channels go to IDLE, all claim bits clear, rr_ptr=0.
  - Reset mid-transaction abandons the transaction with no further memory request.
- Per-channel FSM states: IDLE, READ_WAIT, WRITE_WAIT, RELAY.
- IDLE:
  - Scan consumers from rr_ptr upward, modulo NUM_CONSUMERS. Take the first consumer with (read_valid | write_valid) that is not claimed.
  - On a grant: set the claim bit and record the consumer index.
  - Read: latch the address, drive mem_read_valid=1 next cycle, go to READ_WAIT.
  - Write: latch address and data, drive mem_write_valid=1, go to WRITE_WAIT.
  - Read wins if a consumer asserts both valids.
- Same-cycle multi-channel grants: channels are evaluated in index order. Channel c excludes consumers granted to channels <c in that cycle, so no consumer is ever granted twice.
- rr_ptr update: after any grant cycle, rr_ptr = (last granted consumer index this cycle + 1) mod NUM_CONSUMERS. With no grant, rr_ptr is unchanged.
- READ_WAIT:
  - Hold mem_read_valid/address until mem_read_ready==1.
  - On that cycle: clear mem_read_valid, register mem_read_data into consumer_read_data[k], set consumer_read_ready[k]=1, go to RELAY.
- WRITE_WAIT: same as READ_WAIT, using the write signals and consumer_write_ready[k].
- RELAY:
  - Hold ready=1 while the consumer's valid stays high.
  - When the consumer's valid==0: clear ready and the claim bit, go to IDLE.
  - Minimum 1 cycle in RELAY. consumer_read_data[k] holds its value until that consumer's next read completes.
- Latency: grant is seen at cycle 0. mem_*_valid rises at cycle 1. consumer ready rises 1 cycle after mem_*_ready is seen.
- Address/data are sampled only at grant. Changing consumer inputs afterwards has no effect.
- Fairness: a continuously requesting consumer is granted within NUM_CONSUMERS grant opportunities.
- A consumer valid that drops before grant is never served; no error is flagged.
- Claimed consumers are not rescanned, so the same request is never issued twice.
- mem_read_valid and mem_write_valid of one channel are never both high.

Optional Feature:
- Macro: LSU_MEM_ARBITER_PERF_EN.
- When defined, add two output ports:
  - perf_grant_count (16 bits): total grants.
  - perf_stall_count (16 bits): cycles in which at least one consumer valid is high, unclaimed and not granted.
- Both counters saturate at 16'hFFFF and are cleared by reset.
- When undefined, these ports and their registers do not exist. All other behaviour is identical.

Test Plan:
- Single read, NUM_CHANNELS=1: consumer 2 reads address 0x10; memory returns 0xA5 after 3 cycles.
  -> mem_read_address=0x10. consumer_read_ready[2] rises 1 cycle after mem_read_ready with data 0xA5. Ready drops the cycle after valid drops.
- Round-robin: consumers 0-3 all request reads at once, 1 channel, memory latency 1.
  -> Grant order is 0,1,2,3. A re-request by consumer 0 is served only after 3.
- Two channels: consumers 1 and 3 request together.
  -> Channel 0 serves 1, channel 1 serves 3, same cycle. No consumer appears on both channels.
- Write: consumer 0 writes 0x3C to address 0x20 while consumer 1 reads address 0x20, 1 channel, rr_ptr=0.
  -> Write is issued first. The read then returns 0x3C from the memory model.
- Reset mid-op: assert reset during READ_WAIT.
  -> Next cycle all outputs are 0 and rr_ptr=0. After release, a fresh request is granted normally.
- PERF_EN: 4 simultaneous requests, 1 channel, latency 2.
  -> perf_grant_count=4 and perf_stall_count is nonzero. Forcing the stall counter near 0xFFFF shows it saturating at 0xFFFF.
